wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter AW, default 32, Wishbone address width (matches WB_AD_WIDTH).
REQ-002 Parameter DW, default 32, Wishbone data width (matches WB_DAT_WIDTH); select width is DW/8.
REQ-003 Parameter TIMEOUT, default 255, stall cycles before abort; legal range 0..255; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mN_cyc_i / mN_stb_i / mN_we_i (N=0,1)  input  1 each  master N bus cycle, strobe and write enable.
REQ-007 mN_addr_i  input  AW; mN_wdata_i  input  DW; mN_sel_i  input  DW/8  master N address, write data and byte select.
REQ-008 mN_rdata_o  output  DW  read data returned to master N.
REQ-009 mN_ack_o  output  1  ack to master N; mN_err_o  output  1  timeout abort to master N.
REQ-010 s_cyc_o / s_stb_o / s_we_o  output  1 each; s_addr_o  output  AW; s_wdata_o  output  DW; s_sel_o  output  DW/8  shared slave port.
REQ-011 s_rdata_i  input  DW; s_ack_i  input  1  slave response.
REQ-012 gnt_o  output  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = none.

Function
REQ-013 FSM states are IDLE, BUSY and ABORT; reg last_gnt records the most recently granted master; reg cnt is 8 bits.
REQ-014 A master's request is mN_cyc_i & mN_stb_i.
REQ-015 IDLE, a single request: the requester is granted and the state becomes BUSY on the next edge, so slave signals appear 1 cycle after the request.
REQ-016 IDLE, both requesting: the master not equal to last_gnt is granted (round-robin).
REQ-017 IDLE, no request: stay in IDLE.
REQ-018 On any grant, last_gnt is updated to the granted master and cnt is cleared.
REQ-019 BUSY: s_* outputs equal the granted master's inputs combinationally.
REQ-020 BUSY: the granted master's ack_o = s_ack_i and rdata_o = s_rdata_i.
REQ-021 BUSY: the non-granted master sees ack_o = 0, err_o = 0 and rdata_o = 0, and its request is held off.
REQ-022 The grant is locked for the whole master cycle: consecutive stb/ack beats under a continuous cyc keep the same owner.
REQ-023 BUSY, granted cyc_i low: release to IDLE on the next edge.
REQ-024 After a release, s_cyc_o is 0 during the IDLE cycle, giving one dead cycle between owners.
REQ-025 BUSY, counting: when stb is high, s_ack_i is low and TIMEOUT != 0, cnt increments, saturating at 255.
REQ-026 BUSY, clearing: cnt clears on s_ack_i or when stb is low.
REQ-027 BUSY, abort: cnt == TIMEOUT-1 while still stalled moves the state to ABORT.
REQ-028 ABORT: s_cyc_o and s_stb_o are 0.
REQ-029 ABORT: the owner's err_o is 1 in the first ABORT cycle only (1-cycle pulse), and its ack_o is 0.
REQ-030 ABORT: the state moves to IDLE once the owner's cyc_i is low.
REQ-031 Timeout and ack on the same cycle: the ack wins; it is forwarded, cnt clears and there is no abort.
REQ-032 s_ack_i arriving in IDLE or ABORT (late response) is not forwarded to any master.
REQ-033 When no master is granted, s_* outputs are all 0.
REQ-034 gnt_o is registered and equals the one-hot owner in BUSY and ABORT, and 00 in IDLE.

Reset
REQ-035 While rst = 1, the state is IDLE, gnt_o = 00, cnt = 0, and last_gnt = m1 so that m0 wins the first tie.
REQ-036 While rst = 1, all s_* outputs and all mN_ack_o, mN_err_o and mN_rdata_o are 0.
REQ-037 Reset asserted mid-transfer forces the REQ-035/036 values immediately, without waiting for a clock edge.
REQ-038 After rst deasserts, arbitration resumes on the first rising edge.

Verification
REQ-039 Tie: m0 and m1 both request at cycle 0 after reset -> gnt_o = 01 at cycle 1; m0 completes and drops cyc -> IDLE -> gnt_o = 10.
REQ-040 Lock: m1 owns and issues 3 back-to-back acked beats with cyc held while m0 requests -> gnt_o stays 10 until m1 cyc = 0, then m0 is granted after 1 idle cycle.
REQ-041 Data path: m0 reads addr 0x30000010 and the slave returns 0xDEADBEEF with ack -> m0_rdata_o = 0xDEADBEEF and m0_ack_o = 1 the same cycle; m1_ack_o = 0 and m1_rdata_o = 0.
REQ-042 Timeout: TIMEOUT = 4 and the slave never acks -> s_stb_o is high for 4 cycles, m0_err_o pulses 1 cycle, s_cyc_o = 0; a late s_ack_i is not forwarded; m0 drops cyc -> IDLE.
REQ-043 Ack on the boundary: TIMEOUT = 4 and s_ack_i arrives on the 4th stall cycle -> m0_ack_o = 1, no err, state stays BUSY.
REQ-044 Reset mid-cycle: rst asserted while m1 owns with stb high -> s_cyc_o = 0 and gnt_o = 00 before the next edge; after release a tie grants m0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master round-robin Wishbone arbiter with cycle-locked grants and a stall timeout
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam bit TO_EN = TIMEOUT != 0;
  state_t r_state, w_next;
  logic r_last, r_err;
  logic [1:0] r_gnt, w_req;
  logic [7:0] r_cnt, w_cnt;
  logic w_pick, w_cyc, w_stb, w_we, w_busy, w_abort, w_stall, w_to;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW/8-1:0] w_sel;
  assign w_req   = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign w_pick  = &w_req ? ~r_last : w_req[1];
  // r_last doubles as the owner select while BUSY/ABORT
  assign w_cyc   = r_last ? m1_cyc_i   : m0_cyc_i;
  assign w_stb   = r_last ? m1_stb_i   : m0_stb_i;
  assign w_we    = r_last ? m1_we_i    : m0_we_i;
  assign w_addr  = r_last ? m1_addr_i  : m0_addr_i;
  assign w_wdata = r_last ? m1_wdata_i : m0_wdata_i;
  assign w_sel   = r_last ? m1_sel_i   : m0_sel_i;
  assign w_busy  = r_state == BUSY;
  assign w_abort = r_state == ABORT;
  assign w_stall = w_stb & ~s_ack_i;
  assign w_to    = TO_EN && w_stall && r_cnt == TO_LAST;
  always_comb begin
    w_next = r_state;
    w_cnt  = 8'd0;
    case (r_state)
      IDLE: if (|w_req) w_next = BUSY;
      BUSY: begin
        if (!w_cyc) w_next = IDLE;
        else if (w_to) w_next = ABORT;
        if (TO_EN && w_stall) w_cnt = r_cnt == 8'hFF ? r_cnt : r_cnt + 8'd1;
      end
      default: if (!w_cyc) w_next = IDLE;
    endcase
  end
  // Slave port is only driven in BUSY, so IDLE gives the dead cycle between owners
  assign s_cyc_o    = w_busy & w_cyc;
  assign s_stb_o    = w_busy & w_stb;
  assign s_we_o     = w_busy & w_we;
  assign s_addr_o   = w_busy ? w_addr  : '0;
  assign s_wdata_o  = w_busy ? w_wdata : '0;
  assign s_sel_o    = w_busy ? w_sel   : '0;
  assign m0_ack_o   = w_busy & ~r_last & s_ack_i;
  assign m1_ack_o   = w_busy &  r_last & s_ack_i;
  assign m0_rdata_o = (w_busy & ~r_last) ? s_rdata_i : '0;
  assign m1_rdata_o = (w_busy &  r_last) ? s_rdata_i : '0;
  assign m0_err_o   = w_abort & r_err & ~r_last;
  assign m1_err_o   = w_abort & r_err &  r_last;
  assign gnt_o      = r_gnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_err   <= w_busy && w_next == ABORT;
      if (r_state == IDLE && |w_req) begin
        r_last <= w_pick;
        r_gnt  <= w_pick ? 2'b10 : 2'b01;
      end else if (w_next == IDLE) r_gnt <= 2'b00;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed scenarios plus randomized traffic against a behavioural arbiter model
module tb_wb_arbiter_2m;
  localparam int AW = 32, DW = 32, TO = 4;
  logic clk = 0, rst = 1;
  logic [1:0] cyc, stb, we, req;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic [DW/8-1:0] sel [2];
  logic s_ack;
  logic [DW-1:0] s_rdata;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o, s_wdata_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW/8-1:0] s_sel_o;
  logic [1:0] gnt_o;
  int n_chk = 0, n_fail = 0;
  int own = -1, lastg = 1, stall = 0, m_pick;
  bit ab = 0, errp = 0;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_wdata_i(wdat[0]), .m0_sel_i(sel[0]), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_wdata_i(wdat[1]), .m1_sel_i(sel[1]), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o), .s_rdata_i(s_rdata), .s_ack_i(s_ack), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  assign req = cyc & stb;
  assign m_pick = (req[0] && req[1]) ? 1 - lastg : (req[1] ? 1 : 0);

  // Reference model: who owns the bus, whether it is aborting, and how long it has stalled
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own <= -1; ab <= 0; errp <= 0; stall <= 0; lastg <= 1;
    end else if (own < 0) begin
      if (req != 2'b00) begin
        own <= m_pick; lastg <= m_pick; stall <= 0; ab <= 0; errp <= 0;
      end
    end else if (!ab) begin
      if (!cyc[own]) own <= -1;
      else if (stb[own] && !s_ack) begin
        stall <= stall + 1;
        if (TO > 0 && stall + 1 == TO) begin ab <= 1; errp <= 1; end
      end else stall <= 0;
    end else begin
      errp <= 0;
      if (!cyc[own]) begin own <= -1; ab <= 0; end
    end
  end

  always @(negedge clk) begin
    int o;
    bit busy;
    logic [7:0] ctl;
    o = own < 0 ? 0 : own;
    busy = own >= 0 && !ab;
    ctl = {busy && cyc[o], busy && stb[o],
           busy && own == 0 && s_ack, busy && own == 1 && s_ack,
           ab && errp && own == 0, ab && errp && own == 1,
           own < 0 ? 2'b00 : (own == 0 ? 2'b01 : 2'b10)};
    chk("mdl_ctl", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o}, ctl);
    chk("mdl_rd0", m0_rdata_o, (busy && own == 0) ? s_rdata : '0);
    chk("mdl_rd1", m1_rdata_o, (busy && own == 1) ? s_rdata : '0);
    if (!ab) begin
      chk("mdl_addr", s_addr_o, busy ? addr[o] : '0);
      chk("mdl_wdat", s_wdata_o, busy ? wdat[o] : '0);
      chk("mdl_wesel", {s_we_o, s_sel_o}, busy ? {we[o], sel[o]} : 5'd0);
    end
  end

  initial begin
    cyc = 0; stb = 0; we = 0; s_ack = 0; s_rdata = 0;
    for (int k = 0; k < 2; k++) begin addr[k] = 0; wdat[k] = 0; sel[k] = 0; end
    tick; tick;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_outs", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_rdata", {m0_rdata_o, m1_rdata_o}, 0);
    rst = 0;
    // Tie after reset goes to m0, then m1 after a dead cycle
    cyc = 2'b11; stb = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200; #1;
    chk("tie_idle_gnt", gnt_o, 2'b00);
    tick;
    chk("tie_gnt", gnt_o, 2'b01);
    chk("tie_addr", s_addr_o, 32'h100);
    s_ack = 1; #1;
    chk("tie_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    tick; cyc[0] = 0; stb[0] = 0; s_ack = 0;
    tick;
    chk("tie_rel_gnt", gnt_o, 2'b00);
    chk("tie_dead", s_cyc_o, 0);
    tick;
    chk("tie_m1", gnt_o, 2'b10);
    // Lock: m1 keeps the bus across acked beats while m0 waits
    cyc[0] = 1; stb[0] = 1; s_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lock_gnt", gnt_o, 2'b10);
      chk("lock_ack", {m0_ack_o, m1_ack_o}, 2'b01);
      tick;
    end
    cyc[1] = 0; stb[1] = 0; s_ack = 0; #1;
    chk("lock_hold", gnt_o, 2'b10);
    tick;
    chk("lock_idle", {gnt_o, s_cyc_o}, 3'b000);
    tick;
    chk("lock_m0", gnt_o, 2'b01);
    // Read data path to m0
    we[0] = 0; addr[0] = 32'h3000_0010; s_rdata = 32'hDEAD_BEEF; s_ack = 1; #1;
    chk("dp_addr", s_addr_o, 32'h3000_0010);
    chk("dp_rdata0", m0_rdata_o, 32'hDEAD_BEEF);
    chk("dp_acks", {m0_ack_o, m1_ack_o}, 2'b10);
    chk("dp_rdata1", m1_rdata_o, 0);
    tick; cyc[0] = 0; stb[0] = 0; s_ack = 0;
    tick; tick;
    // Timeout: four stalled strobes, one-cycle err, late ack swallowed
    cyc[0] = 1; stb[0] = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      #1 chk("to_stb", {s_stb_o, m0_err_o}, 2'b10);
      tick;
    end
    chk("to_abort_bus", {s_cyc_o, s_stb_o}, 2'b00);
    chk("to_err", {m0_err_o, m1_err_o, m0_ack_o}, 3'b100);
    chk("to_gnt", gnt_o, 2'b01);
    tick;
    chk("to_err_pulse", m0_err_o, 0);
    s_ack = 1; #1;
    chk("to_late", {m0_ack_o, m1_ack_o}, 2'b00);
    tick; cyc[0] = 0; stb[0] = 0; s_ack = 0;
    tick;
    chk("to_idle", gnt_o, 2'b00);
    // Ack on the last stall cycle beats the timeout
    cyc[0] = 1; stb[0] = 1;
    tick; repeat (3) tick;
    s_ack = 1; #1;
    chk("bnd_ack", m0_ack_o, 1);
    tick; s_ack = 0; #1;
    chk("bnd_busy", {gnt_o, s_cyc_o, m0_err_o}, 4'b0110);
    cyc[0] = 0; stb[0] = 0;
    tick; tick;
    // Asynchronous reset while m1 owns
    cyc[1] = 1; stb[1] = 1;
    tick;
    chk("rm_gnt", gnt_o, 2'b10);
    rst = 1; #1;
    chk("rm_rst", {s_cyc_o, s_stb_o, gnt_o, m1_ack_o, m1_err_o}, 0);
    tick; tick;
    rst = 0; cyc = 2'b11; stb = 2'b11;
    tick;
    chk("rm_tie", gnt_o, 2'b01);
    cyc = 0; stb = 0;
    tick; tick;
    // Random traffic, checked every cycle by the model
    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        cyc[k] = $urandom_range(0, 9) < 8;
        stb[k] = $urandom_range(0, 3) != 0;
        we[k] = 1'($urandom_range(0, 1));
        addr[k] = $urandom;
        wdat[k] = $urandom;
        sel[k] = 4'($urandom_range(0, 15));
      end
      s_ack = $urandom_range(0, 2) == 0;
      s_rdata = $urandom;
      rst = $urandom_range(0, 299) == 0;
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
